// File: rtl/pong_engine.sv
// Pong game core: paddles, ball physics, scoring, serve delay and game over.
// All game state advances on frame_tick while en is high.
module pong_engine #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PAD_W        = 8,
  parameter int PAD_H_SMALL  = 32,
  parameter int PAD_H_LARGE  = 64,
  parameter int PAD_X1       = 16,
  parameter int PAD_X2       = 616,
  parameter int PAD_SPEED    = 4,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        frame_tick,
  input  logic        bat_size,
  input  logic        p1_up,
  input  logic        p1_dn,
  input  logic        p2_up,
  input  logic        p2_dn,
  input  logic        restart,
  output logic [10:0] p1_y,
  output logic [10:0] p2_y,
  output logic [10:0] bx,
  output logic [10:0] by,
  output logic [4:0]  score1,
  output logic [4:0]  score2,
  output logic        game_over,
  output logic        winner
);

  localparam int CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  localparam logic [10:0] PAD_Y0 = 11'((V_RES - PAD_H_LARGE) / 2);
  localparam logic [10:0] BX0    = 11'((H_RES - BALL_SIZE) / 2);
  localparam logic [10:0] BY0    = 11'((V_RES - BALL_SIZE) / 2);
  localparam logic [10:0] BY_MAX = 11'(V_RES - BALL_SIZE);
  localparam logic [10:0] BX_L   = 11'(PAD_X1 + PAD_W);
  localparam logic [10:0] BX_R   = 11'(PAD_X2 - BALL_SIZE);
  localparam logic [4:0]  WIN5   = 5'(WIN_SCORE);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);

  // Signed 13-bit working constants so that negative intermediates never wrap.
  localparam logic signed [12:0] S_ZERO  = 13'sd0;
  localparam logic signed [12:0] S_PSPD  = 13'(PAD_SPEED);
  localparam logic signed [12:0] S_BSPD  = 13'(BALL_SPEED);
  localparam logic signed [12:0] S_BSZ   = 13'(BALL_SIZE);
  localparam logic signed [12:0] S_YMAX  = 13'(V_RES - BALL_SIZE);
  localparam logic signed [12:0] S_XL    = 13'(PAD_X1 + PAD_W);
  localparam logic signed [12:0] S_XR    = 13'(PAD_X2);
  localparam logic signed [12:0] S_HRES  = 13'(H_RES);

  typedef enum logic [1:0] {
    S_SERVE,
    S_PLAY,
    S_POINT,
    S_OVER
  } state_e;

  typedef struct packed {
    state_e      state;
    logic [CW-1:0] serve_cnt;
    logic [10:0] p1_y;
    logic [10:0] p2_y;
    logic [10:0] bx;
    logic [10:0] by;
    logic        dx;       // 1 = moving right
    logic        dy;       // 1 = moving down
    logic [4:0]  score1;
    logic [4:0]  score2;
    logic        game_over;
    logic        winner;
    logic        scorer;   // 0 = player 1 took the last point
  } game_t;

  localparam game_t GAME_RST = '{
    state:     S_SERVE,
    serve_cnt: '0,
    p1_y:      PAD_Y0,
    p2_y:      PAD_Y0,
    bx:        BX0,
    by:        BY0,
    dx:        1'b1,
    dy:        1'b1,
    score1:    5'd0,
    score2:    5'd0,
    game_over: 1'b0,
    winner:    1'b0,
    scorer:    1'b0
  };

  game_t game_q, game_d;

  logic                tick;
  logic signed [12:0]  pad_lim;
  logic signed [12:0]  pad_h_s;
  logic signed [12:0]  bx_s, by_s, p1_s, p2_s;
  logic signed [12:0]  nx, ny;
  logic                ov1, ov2;
  logic [4:0]          score_inc;

  assign tick    = frame_tick & en;
  assign pad_h_s = bat_size ? 13'(PAD_H_LARGE) : 13'(PAD_H_SMALL);
  assign pad_lim = bat_size ? 13'(V_RES - PAD_H_LARGE) : 13'(V_RES - PAD_H_SMALL);

  assign bx_s = $signed({2'b00, game_q.bx});
  assign by_s = $signed({2'b00, game_q.by});
  assign p1_s = $signed({2'b00, game_q.p1_y});
  assign p2_s = $signed({2'b00, game_q.p2_y});

  assign nx = game_q.dx ? (bx_s + S_BSPD) : (bx_s - S_BSPD);
  assign ny = game_q.dy ? (by_s + S_BSPD) : (by_s - S_BSPD);

  // Collision is judged against paddle and ball positions from before this tick.
  assign ov1 = (by_s + S_BSZ > p1_s) && (by_s < p1_s + pad_h_s);
  assign ov2 = (by_s + S_BSZ > p2_s) && (by_s < p2_s + pad_h_s);

  assign score_inc = (game_q.scorer ? game_q.score2 : game_q.score1) + 5'd1;

  function automatic logic [10:0] pad_step(input logic [10:0] y, input logic up,
                                           input logic dn, input logic signed [12:0] lim);
    logic signed [12:0] t;
    t = $signed({2'b00, y});
    if (up && !dn)      t = t - S_PSPD;
    else if (dn && !up) t = t + S_PSPD;
    if (t < S_ZERO)     t = S_ZERO;
    else if (t > lim)   t = lim;
    return t[10:0];
  endfunction

  always_comb begin
    // NOTE: the whole next-state record defaults to the current one first, so
    // every path assigns every field and no latch can be inferred.
    game_d = game_q;
    unique case (game_q.state)
      S_SERVE: begin
        if (tick) begin
          game_d.p1_y = pad_step(game_q.p1_y, p1_up, p1_dn, pad_lim);
          game_d.p2_y = pad_step(game_q.p2_y, p2_up, p2_dn, pad_lim);
          if (game_q.serve_cnt == SERVE_LAST) begin
            game_d.serve_cnt = '0;
            game_d.state     = S_PLAY;
          end else begin
            game_d.serve_cnt = game_q.serve_cnt + CW'(1);
          end
        end
      end

      S_PLAY: begin
        if (tick) begin
          game_d.p1_y = pad_step(game_q.p1_y, p1_up, p1_dn, pad_lim);
          game_d.p2_y = pad_step(game_q.p2_y, p2_up, p2_dn, pad_lim);

          if (ny < S_ZERO) begin
            game_d.by = '0;
            game_d.dy = 1'b1;
          end else if (ny > S_YMAX) begin
            game_d.by = BY_MAX;
            game_d.dy = 1'b0;
          end else begin
            game_d.by = ny[10:0];
          end

          // On a miss bx keeps its last legal value until the ball is recentred.
          if (!game_q.dx) begin
            if (nx <= S_XL && bx_s >= S_XL && ov1) begin
              game_d.bx = BX_L;
              game_d.dx = 1'b1;
            end else if (nx < S_ZERO) begin
              game_d.scorer = 1'b1;
              game_d.state  = S_POINT;
            end else begin
              game_d.bx = nx[10:0];
            end
          end else begin
            if (nx + S_BSZ >= S_XR && bx_s + S_BSZ <= S_XR && ov2) begin
              game_d.bx = BX_R;
              game_d.dx = 1'b0;
            end else if (nx + S_BSZ > S_HRES) begin
              game_d.scorer = 1'b0;
              game_d.state  = S_POINT;
            end else begin
              game_d.bx = nx[10:0];
            end
          end
        end
      end

      S_POINT: begin
        if (tick) begin
          if (game_q.scorer) game_d.score2 = score_inc;
          else               game_d.score1 = score_inc;
          if (score_inc == WIN5) begin
            game_d.game_over = 1'b1;
            game_d.winner    = game_q.scorer;
            game_d.state     = S_OVER;
          end else begin
            game_d.bx    = BX0;
            game_d.by    = BY0;
            game_d.dx    = ~game_q.scorer;
            game_d.state = S_SERVE;
          end
        end
      end

      S_OVER: begin
        // restart acts on any clock, independent of frame_tick and en.
        if (restart) begin
          game_d.score1    = 5'd0;
          game_d.score2    = 5'd0;
          game_d.game_over = 1'b0;
          game_d.bx        = BX0;
          game_d.by        = BY0;
          game_d.dx        = 1'b1;
          game_d.dy        = 1'b1;
          game_d.serve_cnt = '0;
          game_d.state     = S_SERVE;
        end
      end

      default: game_d = GAME_RST;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) game_q <= GAME_RST;
    else     game_q <= game_d;
  end

  assign p1_y      = game_q.p1_y;
  assign p2_y      = game_q.p2_y;
  assign bx        = game_q.bx;
  assign by        = game_q.by;
  assign score1    = game_q.score1;
  assign score2    = game_q.score2;
  assign game_over = game_q.game_over;
  assign winner    = game_q.winner;

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: paddle table plus hand-traced rallies,
// with WIN_SCORE reduced to 3 so a full game fits in a short run.
module tb_pong_engine;

  logic        clk = 1'b0;
  logic        rst, en, frame_tick, bat_size;
  logic        p1_up, p1_dn, p2_up, p2_dn, restart;
  logic [10:0] p1_y, p2_y, bx, by;
  logic [4:0]  score1, score2;
  logic        game_over, winner;

  int checks = 0;
  int errors = 0;

  pong_engine #(.WIN_SCORE(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .frame_tick (frame_tick),
    .bat_size   (bat_size),
    .p1_up      (p1_up),
    .p1_dn      (p1_dn),
    .p2_up      (p2_up),
    .p2_dn      (p2_dn),
    .restart    (restart),
    .p1_y       (p1_y),
    .p2_y       (p2_y),
    .bx         (bx),
    .by         (by),
    .score1     (score1),
    .score2     (score2),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;      // ticks to apply
    logic [3:0] btn;    // {p1_up, p1_dn, p2_up, p2_dn}
    logic       bat;
    int         exp_p1;
    int         exp_p2;
  } pad_vec_t;

  pad_vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    {p1_up, p1_dn, p2_up, p2_dn} = b;
  endtask

  task automatic check_ball(input string name, input int ex, input int ey);
    check({name, "_bx"}, 32'(bx), 32'(ex));
    check({name, "_by"}, 32'(by), 32'(ey));
  endtask

  // Asserts rst between clock edges and checks outputs before the next edge.
  task automatic mid_reset(input bit do_check);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    if (do_check) begin
      check("rst_p1_y", 32'(p1_y), 32'd208);
      check("rst_p2_y", 32'(p2_y), 32'd208);
      check_ball("rst", 316, 236);
      check("rst_score1", 32'(score1), 32'd0);
      check("rst_score2", 32'(score2), 32'd0);
      check("rst_game_over", 32'(game_over), 32'd0);
      check("rst_winner", 32'(winner), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    set_btn(4'b0000);
    frame_tick = 1'b0;
    restart    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; frame_tick = 1'b0; bat_size = 1'b1; restart = 1'b0;
    set_btn(4'b0000);

    vecs[0]  = '{1,  4'b1000, 1'b1, 204, 208};
    vecs[1]  = '{1,  4'b1000, 1'b1, 200, 208};
    vecs[2]  = '{50, 4'b1000, 1'b1, 0,   208};
    vecs[3]  = '{3,  4'b1000, 1'b1, 0,   208};
    vecs[4]  = '{1,  4'b1100, 1'b1, 0,   208};
    vecs[5]  = '{2,  4'b0100, 1'b1, 8,   208};
    vecs[6]  = '{1,  4'b1100, 1'b1, 8,   208};
    vecs[7]  = '{1,  4'b0000, 1'b1, 8,   208};
    vecs[8]  = '{59, 4'b0001, 1'b0, 8,   444};
    vecs[9]  = '{1,  4'b0001, 1'b0, 8,   448};
    vecs[10] = '{2,  4'b0001, 1'b0, 8,   448};
    vecs[11] = '{1,  4'b0000, 1'b1, 8,   416};
    vecs[12] = '{1,  4'b0010, 1'b1, 8,   412};
    vecs[13] = '{1,  4'b0011, 1'b1, 8,   412};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("init_p1_y", 32'(p1_y), 32'd208);
    check_ball("init", 316, 236);

    // Serve delay, en gating, wall bounce, right-paddle bounce, left miss.
    en = 1'b0;
    set_btn(4'b1000);
    tick(5);
    check("en0_p1_y", 32'(p1_y), 32'd208);
    check_ball("en0", 316, 236);
    en = 1'b1;
    set_btn(4'b0001);
    tick(59);  check_ball("serve59", 316, 236);
    tick(1);   check_ball("serve60", 316, 236);
    tick(1);   check_ball("launch", 318, 238);
    tick(117); check_ball("k118", 552, 472);
    tick(1);   check_ball("k119", 554, 472);
    tick(1);   check_ball("k120", 556, 470);
    check("p2_parked_low", 32'(p2_y), 32'd416);
    tick(26);  check_ball("p2_hit", 608, 418);
    check("p2_hit_score1", 32'(score1), 32'd0);
    tick(1);   check_ball("after_hit", 606, 416);
    tick(303); check_ball("k450", 0, 188);
    tick(1);   check_ball("miss_left", 0, 190);
    check("miss_left_score2", 32'(score2), 32'd0);
    tick(1);
    check("point_p2_score2", 32'(score2), 32'd1);
    check("point_p2_score1", 32'(score1), 32'd0);
    check_ball("point_p2", 316, 236);
    tick(60);  check_ball("serve_after_p2", 316, 236);
    tick(1);   check_ball("launch_left", 314, 238);

    // Mid-frame asynchronous reset, then the paddle table.
    mid_reset(1'b1);
    for (int i = 0; i < 14; i++) begin
      set_btn(vecs[i].btn);
      bat_size = vecs[i].bat;
      tick(vecs[i].n);
      check($sformatf("pad%0d_p1_y", i), 32'(p1_y), 32'(vecs[i].exp_p1));
      check($sformatf("pad%0d_p2_y", i), 32'(p2_y), 32'(vecs[i].exp_p2));
    end

    // Three misses by player 2 end the game.
    mid_reset(1'b0);
    bat_size = 1'b0;
    set_btn(4'b0010);
    for (int r = 0; r < 3; r++) begin
      tick(219);
      check($sformatf("rally%0d_bx", r), 32'(bx), 32'd632);
      check($sformatf("rally%0d_pre_score1", r), 32'(score1), 32'(r));
      tick(1);
      check($sformatf("rally%0d_score1", r), 32'(score1), 32'(r + 1));
      if (r < 2) begin
        check_ball($sformatf("rally%0d_recentre", r), 316, 236);
        check($sformatf("rally%0d_game_over", r), 32'(game_over), 32'd0);
      end
    end
    check("over_game_over", 32'(game_over), 32'd1);
    check("over_winner", 32'(winner), 32'd0);
    check("over_score2", 32'(score2), 32'd0);
    check_ball("over", 632, 392);
    check("over_p2_y", 32'(p2_y), 32'd0);

    set_btn(4'b1000);
    tick(5);
    check("frozen_p1_y", 32'(p1_y), 32'd208);
    check("frozen_score1", 32'(score1), 32'd3);
    check("frozen_game_over", 32'(game_over), 32'd1);
    check_ball("frozen", 632, 392);

    set_btn(4'b0000);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart_score1", 32'(score1), 32'd0);
    check("restart_game_over", 32'(game_over), 32'd0);
    check("restart_winner", 32'(winner), 32'd0);
    check_ball("restart", 316, 236);
    tick(60);  check_ball("restart_serve", 316, 236);
    tick(1);   check_ball("restart_launch", 318, 238);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
